// File: rtl/imm_encoder.sv
// Immediate encoder: packs a 32-bit immediate into the I/S/B/U/J fields of a
// base instruction and range-checks it. Out-of-range words become a NOP and
// are counted. Each accepted beat is tagged with an auto-incrementing byte
// address.
module imm_encoder #(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned ERRCNT_W  = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2:0]          in_fmt,
  input  logic [31:0]         in_imm,
  input  logic [31:0]         in_base,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [31:0]         out_instr,
  output logic [ADDR_W-1:0]   out_addr,
  output logic                out_err,
  output logic                err_sticky,
  output logic [ERRCNT_W-1:0] err_count
);

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(4);
  localparam logic [31:0]       NOP  = 32'h0000_0013;

  typedef enum logic {EMPTY, FULL} state_t;

  state_t             state;
  logic [ADDR_W-1:0]  addr_cnt;
  logic [ADDR_W-1:0]  beat_addr;
  logic [31:0]        enc_instr;
  logic               enc_err;
  logic               accept;

  assign in_ready  = (state == EMPTY) || out_ready;
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == FULL);
  // A clear in the accepting cycle restarts numbering from this beat.
  assign beat_addr = clr ? BASE : addr_cnt;

  // Scatter the immediate into its format fields and flag unrepresentable values.
  always_comb begin
    enc_instr = in_base;
    enc_err   = 1'b0;
    case (in_fmt)
      3'd0: begin
        enc_instr[31:20] = in_imm[11:0];
        enc_err = (in_imm[31:11] != '0) && (in_imm[31:11] != '1);
      end
      3'd1: begin
        enc_instr[31:25] = in_imm[11:5];
        enc_instr[11:7]  = in_imm[4:0];
        enc_err = (in_imm[31:11] != '0) && (in_imm[31:11] != '1);
      end
      3'd2: begin
        enc_instr[31]    = in_imm[12];
        enc_instr[30:25] = in_imm[10:5];
        enc_instr[11:8]  = in_imm[4:1];
        enc_instr[7]     = in_imm[11];
        enc_err = ((in_imm[31:12] != '0) && (in_imm[31:12] != '1)) || in_imm[0];
      end
      3'd3: begin
        enc_instr[31:12] = in_imm[31:12];
        enc_err = (in_imm[11:0] != '0);
      end
      3'd4: begin
        enc_instr[31]    = in_imm[20];
        enc_instr[30:21] = in_imm[10:1];
        enc_instr[20]    = in_imm[11];
        enc_instr[19:12] = in_imm[19:12];
        enc_err = ((in_imm[31:20] != '0) && (in_imm[31:20] != '1)) || in_imm[0];
      end
      default: enc_err = 1'b1;
    endcase
  end

  // Output register, handshake FSM, address counter and error bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= EMPTY;
      out_instr  <= '0;
      out_addr   <= BASE;
      out_err    <= 1'b0;
      addr_cnt   <= BASE;
      err_sticky <= 1'b0;
      err_count  <= '0;
    end else begin
      case (state)
        EMPTY:   if (accept) state <= FULL;
        FULL:    if (out_ready && !accept) state <= EMPTY;
        default: state <= EMPTY;
      endcase

      if (accept) begin
        out_instr <= enc_err ? NOP : enc_instr;
        out_err   <= enc_err;
        out_addr  <= beat_addr;
        addr_cnt  <= beat_addr + STEP;
      end else if (clr) begin
        addr_cnt  <= BASE;
      end

      // Clear wipes history first; an erroring beat in the same cycle counts as one.
      if (clr) begin
        err_sticky <= accept && enc_err;
        err_count  <= (accept && enc_err) ? ERRCNT_W'(1) : '0;
      end else if (accept && enc_err) begin
        err_sticky <= 1'b1;
        if (err_count != '1) err_count <= err_count + ERRCNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_imm_encoder.sv
// Randomized bench for imm_encoder with a queue-based reference model plus
// directed literal cases. DUT built with ADDR_W=4 so address wrap shows quickly.
module tb_imm_encoder;

  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clr = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [2:0]    in_fmt = '0;
  logic [31:0]   in_imm = '0;
  logic [31:0]   in_base = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [31:0]   out_instr;
  logic [AW-1:0] out_addr;
  logic          out_err;
  logic          err_sticky;
  logic [7:0]    err_count;

  int errors = 0;
  int checks = 0;

  imm_encoder #(.ADDR_W(AW), .BASE_ADDR(0), .ERRCNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_imm(in_imm), .in_base(in_base),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_addr(out_addr), .out_err(out_err),
    .err_sticky(err_sticky), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Source immediate bit for each instruction bit, -1 when the bit is from the base.
  function automatic int imm_src(int f, int b);
    case (f)
      0: return (b >= 20) ? b - 20 : -1;
      1: return (b >= 25) ? b - 20 : (b >= 7 && b <= 11) ? b - 7 : -1;
      2: return (b == 31) ? 12 : (b >= 25) ? b - 20 : (b >= 8 && b <= 11) ? b - 7 : (b == 7) ? 11 : -1;
      3: return (b >= 12) ? b : -1;
      4: return (b == 31) ? 20 : (b >= 21) ? b - 20 : (b == 20) ? 11 : (b >= 12) ? b : -1;
      default: return -1;
    endcase
  endfunction

  function automatic logic [31:0] m_enc(int f, logic [31:0] imm, logic [31:0] base);
    logic [31:0] r;
    for (int b = 0; b < 32; b++) begin
      int s = imm_src(f, b);
      r[b] = (s >= 0) ? imm[s] : base[b];
    end
    return r;
  endfunction

  // Representability by signed value range and alignment.
  function automatic bit m_err(int f, logic [31:0] imm);
    longint v = longint'($signed(imm));
    case (f)
      0, 1: return (v < -2048) || (v > 2047);
      2:    return (v < -4096) || (v > 4095) || (v % 2 != 0);
      3:    return (imm % 4096) != 0;
      4:    return (v < -1048576) || (v > 1048575) || (v % 2 != 0);
      default: return 1'b1;
    endcase
  endfunction

  typedef struct {
    logic [31:0]   instr;
    logic [AW-1:0] addr;
    logic          err;
  } word_t;

  word_t q[$];
  int    m_addr   = 0;
  bit    m_sticky = 1'b0;
  int    m_cnt    = 0;

  // Compare process: checks DUT against model, then advances model for this edge.
  always @(negedge clk) begin
    if (rst_n) begin
      bit    acc;
      bit    e;
      bit    was_full;
      word_t w;
      was_full = (q.size() != 0);
      check("out_valid", {31'b0, out_valid}, {31'b0, was_full});
      check("in_ready", {31'b0, in_ready}, {31'b0, !was_full || out_ready});
      if (was_full) begin
        check("out_instr", out_instr, q[0].instr);
        check("out_addr", 32'(out_addr), 32'(q[0].addr));
        check("out_err", {31'b0, out_err}, {31'b0, q[0].err});
      end
      check("err_sticky", {31'b0, err_sticky}, {31'b0, m_sticky});
      check("err_count", 32'(err_count), 32'(m_cnt));

      acc = in_valid && (!was_full || out_ready);
      if (was_full && out_ready) void'(q.pop_front());
      if (clr) begin
        m_addr = 0; m_sticky = 1'b0; m_cnt = 0;
      end
      if (acc) begin
        e = m_err(int'(in_fmt), in_imm);
        w.instr = e ? 32'h13 : m_enc(int'(in_fmt), in_imm, in_base);
        w.addr  = AW'(m_addr);
        w.err   = e;
        q.push_back(w);
        m_addr = (m_addr + 4) % (1 << AW);
        if (e) begin
          m_sticky = 1'b1;
          if (m_cnt < 255) m_cnt++;
        end
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic beat(input logic [2:0] f, input logic [31:0] imm, input logic [31:0] base,
                      input logic c, input logic [31:0] ei, input logic [AW-1:0] ea,
                      input logic ee, input string nm);
    @(posedge clk); #1;
    in_valid = 1'b1; in_fmt = f; in_imm = imm; in_base = base; clr = c; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; clr = 1'b0;
    check({nm, " valid"}, {31'b0, out_valid}, 32'd1);
    check({nm, " instr"}, out_instr, ei);
    check({nm, " addr"}, 32'(out_addr), 32'(ea));
    check({nm, " err"}, {31'b0, out_err}, {31'b0, ee});
  endtask

  function automatic logic [31:0] rand_imm();
    int sel = int'($urandom % 5);
    case (sel)
      0: return $urandom;
      1: return 32'($urandom_range(0, 8191)) - 32'd4096;
      2: return $urandom << 12;
      3: return 32'($urandom_range(0, 2097151)) - 32'd1048576;
      default: begin
        logic [31:0] edges [10];
        edges = '{32'd2047, -32'sd2048, 32'd2048, -32'sd2049, 32'd4094,
                  -32'sd4096, 32'd4096, 32'd1048574, -32'sd1048576, 32'd1048576};
        return edges[$urandom % 10];
      end
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0]   held_instr;
    logic [AW-1:0] held_addr;

    // model pinned to hand-computed encodings
    check("model I", m_enc(0, 32'hFFFFFFFF, 32'h00000093), 32'hFFF00093);
    check("model B", m_enc(2, 32'hFFFFFFFC, 32'h00000063), 32'hFE000EE3);
    check("model J", m_enc(4, 32'd8, 32'h0000006F), 32'h0080006F);
    check("model Ierr", {31'b0, m_err(0, 32'd2048)}, 32'd1);

    // reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst out_valid", {31'b0, out_valid}, 32'd0);
    check("rst out_instr", out_instr, 32'd0);
    check("rst out_addr", 32'(out_addr), 32'd0);
    check("rst err_count", 32'(err_count), 32'd0);
    check("rst err_sticky", {31'b0, err_sticky}, 32'd0);
    rst_n = 1'b1;

    beat(3'd0, 32'hFFFFFFFF, 32'h00000093, 1'b0, 32'hFFF00093, 4'h0, 1'b0, "I");
    beat(3'd1, 32'd8, 32'h0020A023, 1'b0, 32'h0020A423, 4'h4, 1'b0, "S");
    beat(3'd2, 32'hFFFFFFFC, 32'h00000063, 1'b0, 32'hFE000EE3, 4'h8, 1'b0, "B");
    beat(3'd4, 32'd8, 32'h0000006F, 1'b0, 32'h0080006F, 4'hC, 1'b0, "J");
    beat(3'd3, 32'h12345000, 32'h000002B7, 1'b0, 32'h123452B7, 4'h0, 1'b0, "U wrap");

    beat(3'd0, 32'd2048, 32'h00000093, 1'b0, 32'h00000013, 4'h4, 1'b1, "I err");
    check("err_count one", 32'(err_count), 32'd1);
    check("err_sticky set", {31'b0, err_sticky}, 32'd1);
    beat(3'd2, 32'd3, 32'h00000063, 1'b0, 32'h00000013, 4'h8, 1'b1, "B odd");
    beat(3'd7, 32'd0, 32'h00000093, 1'b0, 32'h00000013, 4'hC, 1'b1, "fmt7");

    // saturation: 300 back-to-back error words
    @(posedge clk); #1;
    in_valid = 1'b1; in_fmt = 3'd7; out_ready = 1'b1;
    repeat (300) @(posedge clk);
    #1; in_valid = 1'b0;
    check("err_count sat", 32'(err_count), 32'd255);

    // clear with no accept
    @(posedge clk); #1; clr = 1'b1;
    @(posedge clk); #1; clr = 1'b0;
    check("clr err_count", 32'(err_count), 32'd0);
    check("clr err_sticky", {31'b0, err_sticky}, 32'd0);

    // backpressure
    out_ready = 1'b0; in_valid = 1'b1; in_fmt = 3'd0; in_imm = 32'd5; in_base = 32'h13;
    @(posedge clk); #1;
    in_imm = -32'sd5;
    held_instr = out_instr; held_addr = out_addr;
    check("bp held instr", held_instr, 32'h00500013);
    for (int i = 0; i < 5; i++) begin
      check("bp in_ready", {31'b0, in_ready}, 32'd0);
      check("bp instr stable", out_instr, held_instr);
      check("bp addr stable", 32'(out_addr), 32'(held_addr));
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp second word", out_instr, 32'hFFB00013);
    @(posedge clk); #1;

    // clear together with accept, then wrap sequence
    beat(3'd0, 32'd1, 32'h13, 1'b1, 32'h00100013, 4'h0, 1'b0, "clr+acc");
    check("clr+acc err_count", 32'(err_count), 32'd0);
    beat(3'd0, 32'd2, 32'h13, 1'b0, 32'h00200013, 4'h4, 1'b0, "wrap1");
    beat(3'd0, 32'd3, 32'h13, 1'b0, 32'h00300013, 4'h8, 1'b0, "wrap2");
    beat(3'd0, 32'd4, 32'h13, 1'b0, 32'h00400013, 4'hC, 1'b0, "wrap3");
    beat(3'd0, 32'd5, 32'h13, 1'b0, 32'h00500013, 4'h0, 1'b0, "wrap4");
    beat(3'd5, 32'd0, 32'h13, 1'b1, 32'h00000013, 4'h0, 1'b1, "clr+err");
    check("clr+err count", 32'(err_count), 32'd1);

    // reset while FULL
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; in_fmt = 3'd0; in_imm = 32'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("pre-reset valid", {31'b0, out_valid}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("async rst valid", {31'b0, out_valid}, 32'd0);
    check("async rst addr", 32'(out_addr), 32'd0);
    check("async rst count", 32'(err_count), 32'd0);
    q.delete(); m_addr = 0; m_sticky = 1'b0; m_cnt = 0;
    #1 rst_n = 1'b1;

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      clr       = ($urandom % 40) == 0;
      in_fmt    = (($urandom % 8) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom % 5);
      in_imm    = rand_imm();
      in_base   = $urandom;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; clr = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("drained", 32'(q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
